// File: rtl/fetch_decode_skid_reg_if.sv
// Handshake and payload bundle between fetch and decode across the IF/ID skid register.
// The master side is the surrounding pipeline; the slave side is the register itself.
interface fetch_decode_skid_reg_if #(
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 5,
  parameter int GHR_W   = 5,
  parameter int CNT_W   = 16
);
  logic               flush;
  logic               f_valid;
  logic               f_ready;
  logic [INSTR_W-1:0] instruction_F;
  logic [ADDR_W-1:0]  PC_F;
  logic [ADDR_W-1:0]  next_address_F;
  logic [ADDR_W-1:0]  BTA_F;
  logic               prediction_F;
  logic [GHR_W-1:0]   ghr_F;
  logic               d_ready;
  logic               d_valid;
  logic [INSTR_W-1:0] instruction_D;
  logic [ADDR_W-1:0]  PC_D;
  logic [ADDR_W-1:0]  next_address_D;
  logic [ADDR_W-1:0]  BTA_D;
  logic               prediction_D;
  logic [GHR_W-1:0]   ghr_D;
  logic [CNT_W-1:0]   bubble_count;

  modport master (
    output flush, f_valid, instruction_F, PC_F, next_address_F, BTA_F, prediction_F, ghr_F, d_ready,
    input  f_ready, d_valid, instruction_D, PC_D, next_address_D, BTA_D, prediction_D, ghr_D,
           bubble_count
  );

  modport slave (
    input  flush, f_valid, instruction_F, PC_F, next_address_F, BTA_F, prediction_F, ghr_F, d_ready,
    output f_ready, d_valid, instruction_D, PC_D, next_address_D, BTA_D, prediction_D, ghr_D,
           bubble_count
  );
endinterface

// File: rtl/fetch_decode_skid_reg.sv
// IF/ID pipeline register with valid/ready handshake, one-entry skid buffer,
// flush to NOP and a saturating decode-side bubble counter.
module fetch_decode_skid_reg #(
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 5,
  parameter int GHR_W   = 5,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  fetch_decode_skid_reg_if.slave    bus
);

  localparam int PAY_W = INSTR_W + 3 * ADDR_W + 1 + GHR_W;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_FULL  = 2'b01;
  localparam logic [1:0] ST_SKID  = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [PAY_W-1:0] main_q, main_d;
  logic [PAY_W-1:0] skid_q, skid_d;
  logic             f_ready_q;
  logic             d_valid_q;
  logic [CNT_W-1:0] bubble_q;
  logic [PAY_W-1:0] pay_in_s;
  logic             f_fire_s;

  assign pay_in_s = {bus.instruction_F, bus.PC_F, bus.next_address_F, bus.BTA_F,
                     bus.prediction_F, bus.ghr_F};
  assign f_fire_s = bus.f_valid & f_ready_q;

  // Next-state and slot updates; flush wins over any concurrent handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
      main_d  = {PAY_W{1'b0}};
      skid_d  = {PAY_W{1'b0}};
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (f_fire_s) begin
            state_d = ST_FULL;
            main_d  = pay_in_s;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (bus.d_ready) begin
            if (f_fire_s) begin
              main_d = pay_in_s;
            end else begin
              state_d = ST_EMPTY;
              main_d  = {PAY_W{1'b0}};
            end
          end else if (f_fire_s) begin
            state_d = ST_SKID;
            skid_d  = pay_in_s;
          end else begin
            state_d = ST_FULL;
          end
        end
        ST_SKID: begin
          if (bus.d_ready) begin
            state_d = ST_FULL;
            main_d  = skid_q;
            skid_d  = {PAY_W{1'b0}};
          end else begin
            state_d = ST_SKID;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = {PAY_W{1'b0}};
          skid_d  = {PAY_W{1'b0}};
        end
      endcase
    end
  end

  // State, slots and registered handshake flags derived from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_EMPTY;
      main_q    <= {PAY_W{1'b0}};
      skid_q    <= {PAY_W{1'b0}};
      f_ready_q <= 1'b1;
      d_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      f_ready_q <= (state_d != ST_SKID);
      d_valid_q <= (state_d != ST_EMPTY);
    end
  end

  // Saturating count of cycles where decode was ready but had nothing to take.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_q <= {CNT_W{1'b0}};
    end else if (bus.d_ready && !d_valid_q && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_q <= bubble_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      bubble_q <= bubble_q;
    end
  end

  assign bus.f_ready      = f_ready_q;
  assign bus.d_valid      = d_valid_q;
  assign bus.bubble_count = bubble_q;
  assign {bus.instruction_D, bus.PC_D, bus.next_address_D, bus.BTA_D,
          bus.prediction_D, bus.ghr_D} = main_q;

endmodule

// File: tb/tb_fetch_decode_skid_reg.sv
// Directed bench for fetch_decode_skid_reg: handshake, skid, flush, bubble counter and async reset.
module tb_fetch_decode_skid_reg;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  fetch_decode_skid_reg_if #(.INSTR_W(32), .ADDR_W(5), .GHR_W(5), .CNT_W(16)) bus ();
  fetch_decode_skid_reg_if #(.INSTR_W(32), .ADDR_W(5), .GHR_W(5), .CNT_W(2))  bus2 ();

  fetch_decode_skid_reg #(.INSTR_W(32), .ADDR_W(5), .GHR_W(5), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  fetch_decode_skid_reg #(.INSTR_W(32), .ADDR_W(5), .GHR_W(5), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fv, input logic [4:0] pc, input logic [31:0] ins, input logic dr);
    bus.f_valid        = fv;
    bus.PC_F           = pc;
    bus.instruction_F  = ins;
    bus.next_address_F = pc + 5'd1;
    bus.BTA_F          = pc ^ 5'h1F;
    bus.prediction_F   = pc[0];
    bus.ghr_F          = pc ^ 5'h0A;
    bus.d_ready        = dr;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0);
    bus2.flush = 1'b0;
    bus2.f_valid = 1'b0;
    bus2.instruction_F = 32'd0;
    bus2.PC_F = 5'd0;
    bus2.next_address_F = 5'd0;
    bus2.BTA_F = 5'd0;
    bus2.prediction_F = 1'b0;
    bus2.ghr_F = 5'd0;
    bus2.d_ready = 1'b1;
    step();
    step();
    check_eq("rst_d_valid", {31'd0, bus.d_valid}, 32'd0);
    check_eq("rst_f_ready", {31'd0, bus.f_ready}, 32'd1);
    check_eq("rst_pc_d", {27'd0, bus.PC_D}, 32'd0);
    check_eq("rst_bubble", {16'd0, bus.bubble_count}, 32'd0);
    reset = 1'b1;

    // Idle cycles with decode ready: bubble counting and saturation.
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    step();
    step();
    check_eq("sat_bubble_2", {30'd0, bus2.bubble_count}, 32'd2);
    step();
    check_eq("sat_bubble_3", {30'd0, bus2.bubble_count}, 32'd3);
    step();
    step();
    check_eq("bubble_5", {16'd0, bus.bubble_count}, 32'd5);
    check_eq("idle_d_valid", {31'd0, bus.d_valid}, 32'd0);
    step();
    check_eq("sat_bubble_hold", {30'd0, bus2.bubble_count}, 32'd3);
    check_eq("bubble_6", {16'd0, bus.bubble_count}, 32'd6);

    // First accept: visible one clock after the accepting edge.
    drive(1'b1, 5'd3, 32'h00A50513, 1'b1);
    step();
    check_eq("t1_d_valid", {31'd0, bus.d_valid}, 32'd1);
    check_eq("t1_pc_d", {27'd0, bus.PC_D}, 32'd3);
    check_eq("t1_instr_d", bus.instruction_D, 32'h00A50513);
    check_eq("t1_f_ready", {31'd0, bus.f_ready}, 32'd1);
    check_eq("t1_bubble", {16'd0, bus.bubble_count}, 32'd7);

    // Streaming with decode always ready.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i[4:0], 32'h0000_1000 + i, 1'b1);
      step();
      check_eq("stream_pc_d", {27'd0, bus.PC_D}, i);
      check_eq("stream_instr_d", bus.instruction_D, 32'h0000_1000 + i);
      check_eq("stream_f_ready", {31'd0, bus.f_ready}, 32'd1);
    end
    check_eq("stream_next_d", {27'd0, bus.next_address_D}, 32'd8);
    check_eq("stream_bta_d", {27'd0, bus.BTA_D}, 32'h18);
    check_eq("stream_pred_d", {31'd0, bus.prediction_D}, 32'd1);
    check_eq("stream_ghr_d", {27'd0, bus.ghr_D}, 32'h0D);
    check_eq("stream_bubble", {16'd0, bus.bubble_count}, 32'd7);

    // Backpressure: skid captures the word offered while decode stalls.
    drive(1'b1, 5'd4, 32'h0000_0004, 1'b1);
    step();
    check_eq("t3_pc_d_4", {27'd0, bus.PC_D}, 32'd4);
    drive(1'b1, 5'd5, 32'h0000_0005, 1'b0);
    step();
    check_eq("t3_hold_pc_d", {27'd0, bus.PC_D}, 32'd4);
    check_eq("t3_skid_f_ready", {31'd0, bus.f_ready}, 32'd0);
    check_eq("t3_skid_d_valid", {31'd0, bus.d_valid}, 32'd1);
    drive(1'b1, 5'd6, 32'h0000_0006, 1'b1);
    step();
    check_eq("t3_drain_pc_d", {27'd0, bus.PC_D}, 32'd5);
    check_eq("t3_drain_instr", bus.instruction_D, 32'h0000_0005);
    check_eq("t3_drain_f_ready", {31'd0, bus.f_ready}, 32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    step();
    check_eq("t3_no_pc6_valid", {31'd0, bus.d_valid}, 32'd0);
    check_eq("t3_no_pc6_pc_d", {27'd0, bus.PC_D}, 32'd0);

    // Flush while in the skid state with a concurrent offer and decode ready.
    drive(1'b1, 5'd8, 32'h0000_0008, 1'b0);
    step();
    drive(1'b1, 5'd9, 32'h0000_0009, 1'b0);
    step();
    check_eq("t4_skid_f_ready", {31'd0, bus.f_ready}, 32'd0);
    check_eq("t4_skid_pc_d", {27'd0, bus.PC_D}, 32'd8);
    bus.flush = 1'b1;
    drive(1'b1, 5'd10, 32'h0000_000A, 1'b1);
    step();
    bus.flush = 1'b0;
    check_eq("t4_flush_d_valid", {31'd0, bus.d_valid}, 32'd0);
    check_eq("t4_flush_pc_d", {27'd0, bus.PC_D}, 32'd0);
    check_eq("t4_flush_instr", bus.instruction_D, 32'd0);
    check_eq("t4_flush_bta", {27'd0, bus.BTA_D}, 32'd0);
    check_eq("t4_flush_ghr", {27'd0, bus.ghr_D}, 32'd0);
    check_eq("t4_flush_f_ready", {31'd0, bus.f_ready}, 32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    step();
    check_eq("t4_post_d_valid", {31'd0, bus.d_valid}, 32'd0);
    check_eq("t4_post_pc_d", {27'd0, bus.PC_D}, 32'd0);
    check_eq("t4_bubble_kept", {16'd0, bus.bubble_count}, 32'd8);

    // Asynchronous reset mid-cycle while in the skid state.
    drive(1'b1, 5'd12, 32'h0000_000C, 1'b0);
    step();
    drive(1'b1, 5'd13, 32'h0000_000D, 1'b0);
    step();
    check_eq("t6_skid_f_ready", {31'd0, bus.f_ready}, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check_eq("t6_async_d_valid", {31'd0, bus.d_valid}, 32'd0);
    check_eq("t6_async_pc_d", {27'd0, bus.PC_D}, 32'd0);
    check_eq("t6_async_instr", bus.instruction_D, 32'd0);
    check_eq("t6_async_f_ready", {31'd0, bus.f_ready}, 32'd1);
    check_eq("t6_async_bubble", {16'd0, bus.bubble_count}, 32'd0);
    step();
    reset = 1'b1;
    drive(1'b1, 5'd1, 32'h0000_0001, 1'b1);
    step();
    check_eq("t6_first_d_valid", {31'd0, bus.d_valid}, 32'd1);
    check_eq("t6_first_pc_d", {27'd0, bus.PC_D}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
